// File: rtl/ascon_perm_sched_pkg.sv
// Shared types, constants and helpers for the Ascon permutation scheduler.
// State layout: element [i] holds Ascon word x_i.
package ascon_perm_sched_pkg;

    typedef logic [4:0][63:0] type_state;

    typedef enum logic [1:0] {
        P12  = 2'b00,
        P8   = 2'b01,
        P6   = 2'b10,
        PRSV = 2'b11
    } type_nrounds;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } type_sched_state;

    localparam int ROUND_MAX = 12;

    // Constant for round index r: high nibble 15-r, low nibble r.
    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'(4'd15 - r), r};
    endfunction

    // Index of the first round for p^a; the reserved encoding runs as p12.
    function automatic logic [3:0] nrounds_to_first(input type_nrounds n);
        case (n)
            P8:      return 4'd4;
            P6:      return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One Ascon round: constant addition, bitsliced 5-bit S-box, linear diffusion.
module ascon_round
    import ascon_perm_sched_pkg::*;
(
    input  type_state  state_i,
    input  logic [7:0] const_i,
    output type_state  state_o
);

    type_state added;
    type_state pre;
    type_state chi;
    type_state subst;

    always_comb begin
        added    = state_i;
        added[2] = state_i[2] ^ {56'd0, const_i};
    end

    // S-box as input mixing, chi-like nonlinear step, then output mixing.
    always_comb begin
        pre    = added;
        pre[0] = added[0] ^ added[4];
        pre[4] = added[4] ^ added[3];
        pre[2] = added[2] ^ added[1];
        chi    = pre;
        for (int i = 0; i < 5; i++) begin
            chi[i] = pre[i] ^ (~pre[(i + 1) % 5] & pre[(i + 2) % 5]);
        end
        subst    = chi;
        subst[1] = chi[1] ^ chi[0];
        subst[0] = chi[0] ^ chi[4];
        subst[3] = chi[3] ^ chi[2];
        subst[2] = ~chi[2];
    end

    always_comb begin
        state_o    = subst;
        state_o[0] = subst[0] ^ ror64(subst[0], 19) ^ ror64(subst[0], 28);
        state_o[1] = subst[1] ^ ror64(subst[1], 61) ^ ror64(subst[1], 39);
        state_o[2] = subst[2] ^ ror64(subst[2], 1)  ^ ror64(subst[2], 6);
        state_o[3] = subst[3] ^ ror64(subst[3], 10) ^ ror64(subst[3], 17);
        state_o[4] = subst[4] ^ ror64(subst[4], 7)  ^ ror64(subst[4], 41);
    end

endmodule

// File: rtl/ascon_perm_sched.sv
// Runs p12/p8/p6 over a registered 320-bit state, UNROLL rounds per clock.
// Handshake: start_i is accepted only in IDLE or DONE; done_o pulses one cycle with the result on state_o.
module ascon_perm_sched
    import ascon_perm_sched_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [1:0] nrounds_i,
    input  type_state  state_i,
    output type_state  state_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] round_o
);

    if (!(UNROLL == 1 || UNROLL == 2)) begin : g_bad_unroll
        $error("ascon_perm_sched: UNROLL must be 1 or 2");
    end

    type_sched_state fsm_q, fsm_d;
    type_state       state_q, state_d;
    logic [3:0]      rcnt_q, rcnt_d;
    logic [3:0]      rcnt_step;
    type_nrounds     nrounds;
    type_state       chain [UNROLL+1];

    assign nrounds   = type_nrounds'(nrounds_i);
    assign rcnt_step = rcnt_q + 4'(UNROLL);
    assign chain[0]  = state_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        ascon_round u_round (
            .state_i (chain[g]),
            .const_i (round_const(rcnt_q + 4'(g))),
            .state_o (chain[g+1])
        );
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            rcnt_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rcnt_d  = rcnt_q;
        case (fsm_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = state_i;
                    rcnt_d  = nrounds_to_first(nrounds);
                    fsm_d   = ST_RUN;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                state_d = chain[UNROLL];
                rcnt_d  = rcnt_step;
                if (rcnt_step == 4'(ROUND_MAX)) begin
                    fsm_d = ST_DONE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    assign state_o = state_q;
    assign busy_o  = (fsm_q == ST_RUN);
    assign done_o  = (fsm_q == ST_DONE);
    assign round_o = rcnt_q;

    cover property (@(posedge clock_i) disable iff (reset_i)
        start_i && (fsm_q != ST_RUN) && (nrounds == PRSV));

endmodule

// File: tb/tb_ascon_perm_sched.sv
// Bench for ascon_perm_sched: UNROLL=1 and UNROLL=2 instances checked against a
// table-driven Ascon model, with latency, round index and handshake checks.
module tb_ascon_perm_sched;
    import ascon_perm_sched_pkg::*;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    logic        clock;
    logic        reset;
    logic        start [2];
    logic [1:0]  nrounds;
    type_state   state_in;
    type_state   state_out [2];
    logic        busy [2];
    logic        done [2];
    logic [3:0]  round_idx [2];

    int          n_checks;
    int          n_errors;
    int          cyc;
    int          exp_r [2];
    logic [319:0] exp_q0 [$];
    logic [319:0] exp_q1 [$];
    int          due_q0 [$];
    int          due_q1 [$];

    ascon_perm_sched #(.UNROLL(1)) u_dut1 (
        .clock_i(clock), .reset_i(reset), .start_i(start[0]), .nrounds_i(nrounds),
        .state_i(state_in), .state_o(state_out[0]), .busy_o(busy[0]),
        .done_o(done[0]), .round_o(round_idx[0])
    );

    ascon_perm_sched #(.UNROLL(2)) u_dut2 (
        .clock_i(clock), .reset_i(reset), .start_i(start[1]), .nrounds_i(nrounds),
        .state_i(state_in), .state_o(state_out[1]), .busy_o(busy[1]),
        .done_o(done[1]), .round_o(round_idx[1])
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;
    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // reference model
    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        logic [63:0] y;
        for (int b = 0; b < 64; b++) y[b] = x[(b + n) % 64];
        return y;
    endfunction

    function automatic type_state model_round(input type_state s, input int r);
        type_state t;
        logic [7:0] rc;
        logic [4:0] o;
        rc = 8'(((15 - r) << 4) | r);
        s[2][7:0] = s[2][7:0] ^ rc;
        for (int b = 0; b < 64; b++) begin
            o = SBOX[{s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]}];
            t[0][b] = o[4];
            t[1][b] = o[3];
            t[2][b] = o[2];
            t[3][b] = o[1];
            t[4][b] = o[0];
        end
        s[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
        s[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
        s[2] = t[2] ^ rotr(t[2], 1)  ^ rotr(t[2], 6);
        s[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
        s[4] = t[4] ^ rotr(t[4], 7)  ^ rotr(t[4], 41);
        return s;
    endfunction

    function automatic int rounds_of(input logic [1:0] nr);
        case (nr)
            2'b01:   return 8;
            2'b10:   return 6;
            default: return 12;
        endcase
    endfunction

    function automatic type_state model_perm(input type_state s, input logic [1:0] nr);
        for (int r = 12 - rounds_of(nr); r < 12; r++) s = model_round(s, r);
        return s;
    endfunction

    function automatic type_state rand_state();
        type_state s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    // driver tasks (called at a negedge)
    task automatic start_perm(input int u, input logic [1:0] nr, input type_state st, input int hold);
        int a;
        a = rounds_of(nr);
        nrounds  = nr;
        state_in = st;
        start[u] = 1'b1;
        exp_r[u] = 12 - a;
        if (u == 0) begin
            exp_q0.push_back(model_perm(st, nr));
            due_q0.push_back(cyc + a + 1);
        end else begin
            exp_q1.push_back(model_perm(st, nr));
            due_q1.push_back(cyc + a / 2 + 1);
        end
        repeat (hold) @(negedge clock);
        start[u] = 1'b0;
    endtask

    task automatic wait_done(input int u, input int budget);
        bit seen;
        seen = done[u];
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clock);
            seen = done[u];
        end
        if (!seen) check_eq("done_timeout", 320'(seen), 320'd1);
    endtask

    task automatic run_one(input int u, input logic [1:0] nr, input type_state st);
        start_perm(u, nr, st, 1);
        wait_done(u, 40);
    endtask

    // scoreboard / monitor
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (busy[i] || done[i]) check_eq("busy_done_excl", 320'(busy[i] & done[i]), 320'd0);
            if (busy[i]) begin
                check_eq("round_idx", 320'(round_idx[i]), 320'(exp_r[i]));
                exp_r[i] = exp_r[i] + i + 1;
            end
            if (done[i]) begin
                if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                    check_eq("spurious_done", 320'd1, 320'd0);
                end else if (i == 0) begin
                    check_eq("result_u1", state_out[0], exp_q0.pop_front());
                    check_eq("done_cycle_u1", 320'(cyc), 320'(due_q0.pop_front()));
                end else begin
                    check_eq("result_u2", state_out[1], exp_q1.pop_front());
                    check_eq("done_cycle_u2", 320'(cyc), 320'(due_q1.pop_front()));
                end
            end
        end
    end

    // stimulus
    initial begin
        type_state s_a, s_b;
        n_checks = 0;
        n_errors = 0;
        exp_r    = '{0, 0};
        reset    = 1'b1;
        start    = '{1'b0, 1'b0};
        nrounds  = 2'b00;
        state_in = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_busy", 320'(busy[i]), 320'd0);
            check_eq("rst_done", 320'(done[i]), 320'd0);
            check_eq("rst_state", state_out[i], 320'd0);
            check_eq("rst_round", 320'(round_idx[i]), 320'd0);
        end
        @(negedge clock);

        s_a = rand_state();
        s_b = rand_state();
        for (int u = 0; u < 2; u++) begin
            run_one(u, 2'b00, '0);
            @(negedge clock);
            run_one(u, 2'b10, s_a);
            @(negedge clock);
            run_one(u, 2'b01, s_b);
            @(negedge clock);
            run_one(u, 2'b11, s_a);
            @(negedge clock);
            run_one(u, 2'b00, s_a);
            @(negedge clock);
        end

        // start held high through RUN, then back-to-back restarts from DONE
        for (int u = 0; u < 2; u++) begin
            start_perm(u, 2'b10, s_b, 3);
            wait_done(u, 40);
            start_perm(u, 2'b01, s_a, 1);
            wait_done(u, 40);
            start_perm(u, 2'b11, s_b, 1);
            wait_done(u, 40);
            @(negedge clock);
            check_eq("idle_after_done", 320'(busy[u] | done[u]), 320'd0);
        end

        for (int k = 0; k < 8; k++) begin
            int u;
            u = k % 2;
            start_perm(u, 2'($urandom_range(0, 3)), rand_state(), 1);
            wait_done(u, 40);
            if ($urandom_range(0, 1) == 0) @(negedge clock);
        end
        repeat (2) @(negedge clock);

        // reset in the middle of a p12 run: no result, no done pulse
        start_perm(0, 2'b00, s_a, 1);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        exp_q0.delete();
        due_q0.delete();
        @(negedge clock);
        reset = 1'b0;
        check_eq("midrst_busy", 320'(busy[0]), 320'd0);
        check_eq("midrst_done", 320'(done[0]), 320'd0);
        check_eq("midrst_state", state_out[0], 320'd0);
        check_eq("midrst_round", 320'(round_idx[0]), 320'd0);
        repeat (20) @(negedge clock);
        check_eq("midrst_idle", 320'(busy[0]), 320'd0);

        check_eq("pending_u1", 320'(exp_q0.size()), 320'd0);
        check_eq("pending_u2", 320'(exp_q1.size()), 320'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ascon_perm_sched.md
Name: ascon_perm_sched

Overview:
- Sequences the Ascon permutation p^a for a ∈ {12, 8, 6} over a 320-bit type_state register.
- Generates the round counter and round constants, and applies UNROLL rounds per clock through a combinational round datapath (constant addition, substitution, linear layer).
- Sits between the Ascon mode FSM (init/AD/plaintext/finalisation) and the round datapath, with a start/done handshake.

Parameters:
- UNROLL, 1: rounds applied per clock; legal values 1 or 2 (both divide 12, 8 and 6). Any other value fails an elaboration-time assertion.

Ports:
- clock_i  in  1  system clock, rising edge
- reset_i  in  1  reset, synchronous, active-high
- start_i  in  1  request one permutation; sampled in IDLE or DONE
- nrounds_i  in  2  00=p12, 01=p8, 10=p6, 11=reserved (treated as p12); sampled with start_i
- state_i  in  320 (type_state)  input state; sampled with start_i
- state_o  out  320 (type_state)  state register; final result is valid while done_o=1 and held until the next accepted start
- busy_o  out  1  high in RUN
- done_o  out  1  single-cycle pulse; result is valid
- round_o  out  4  current round index r (0..11), for debug and monitors

Behaviour:
- Reset (sync, active-high): FSM=IDLE, state_q=0, rcnt=0, busy_o=0, done_o=0, round_o=0. Reset overrides every other input, including mid-RUN; no done pulse is produced for an aborted permutation.
- Round index: r runs from 12-a to 11. Round constant = {4'(15-r), 4'(r)}, XORed into the low byte of x2. The resulting sequence is 0xf0, 0xe1, 0xd2, 0xc3, 0xb4, 0xa5, 0x96, 0x87, 0x78, 0x69, 0x5a, 0x4b.
- States: IDLE, RUN, DONE. All outputs are registered or derived from state.
- IDLE:
  - start_i=1: state_q <= state_i; rcnt <= 12 - a (a from nrounds_i); go to RUN.
  - start_i=0: hold.
- RUN:
  - Each clock: state_q <= round^UNROLL(state_q), using constants for r=rcnt .. rcnt+UNROLL-1; rcnt <= rcnt + UNROLL.
  - If rcnt + UNROLL = 12, go to DONE.
  - start_i is ignored in RUN; no queuing.
- DONE:
  - done_o=1 for exactly this cycle; state_o = result.
  - start_i=1: accepted exactly as in IDLE (back-to-back permutations).
  - start_i=0: go to IDLE.
- Latency: start accepted at edge E0 → rounds applied at edges E1..E(a/UNROLL) → done_o=1 in the cycle after edge E(a/UNROLL).
  - UNROLL=1: done_o rises a+1 cycles after the start cycle.
  - Total occupancy is a/UNROLL + 1 cycles; a back-to-back restart from DONE adds no idle cycle.
- busy_o=1 exactly in RUN. done_o and busy_o are never both 1.
- round_o = rcnt. rcnt wraps nowhere: it is reloaded on every start and is never incremented outside RUN.
- state_o holds its value in IDLE and DONE; upstream may read it any time after done_o.
- nrounds_i=11 behaves identically to 00 (12 rounds). An SVA cover flags its use.
- The datapath is purely combinational between state_q and its next value. No output depends combinationally on start_i.

Decomposition:
- ascon_pack additions:
  - Typedef type_nrounds (2-bit enum: P12, P8, P6, PRSV).
  - Constant ROUND_MAX=12.
  - Function round_const(r) returning the 8-bit constant.
  - Function nrounds_to_first(type_nrounds) returning 12-a.
  - Typedef for the FSM state enum.
- Sub-module ascon_round: one full round with inputs type_state and an 8-bit constant, output type_state.
  - Internally it is the existing constant-addition, substitution and linear-layer modules chained in that order.
  - ascon_perm_sched instantiates UNROLL copies of it in a generate loop, chained.

Test Plan:
- Reset mid-RUN: start p12, assert reset_i at cycle 5 → next cycle busy_o=0, done_o=0, state_o=0, round_o=0; no done pulse follows.
- p12, UNROLL=1, state_i=0: round_o steps 0..11, applied constants 0xf0..0x4b in order, done_o high exactly 13 cycles after the start cycle, state_o equals the golden C-model p12(0).
- p6 from a random state: first constant 0x96, last 0x4b; done_o after 7 cycles; state_o matches the golden p6. Repeat p8: first constant 0xb4, done_o after 9 cycles.
- UNROLL=2 with p12/p8/p6 on the same inputs: results are bit-identical to UNROLL=1; done_o after 7/5/4 cycles.
- Handshake: start_i held high during RUN is ignored (one done per accepted start); start_i=1 in the DONE cycle launches the next permutation with no gap; busy_o and done_o are never both high.
- nrounds_i=11: behaves exactly as p12 (constant 0xf0 first, 13-cycle latency, same result).
